// File: rtl/down_timer_if.sv
// rtl/down_timer_if.sv - control/status bundle for down_timer.
// Optional `periodic` input exists only when DOWN_TIMER_AUTO_RELOAD_EN is defined.
interface down_timer_if #(
  parameter int WIDTH = 16
);
  logic             cen;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic             periodic;
`endif
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             sync_unf;

  modport master (
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    output periodic,
`endif
    output cen, load, load_val, start, stop,
    input  q, busy, done, sync_unf
  );

  modport slave (
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    input  periodic,
`endif
    input  cen, load, load_val, start, stop,
    output q, busy, done, sync_unf
  );
endinterface

// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable start/stop down-counter with done pulse and borrow output.
// Define DOWN_TIMER_AUTO_RELOAD_EN to enable periodic auto-reload at terminal count.
module down_timer #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RELOAD_INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  down_timer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] r_eff;
  logic             terminal;
  logic             reload_hit;

  // A load in the same cycle as start takes effect for that start.
  assign r_eff    = bus.load ? bus.load_val : reload_q;
  assign terminal = (state_q == RUN) && (q_q == WIDTH'(1)) && bus.cen && !bus.stop;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  assign reload_hit = bus.periodic && (reload_q != '0);
`else
  assign reload_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (bus.load) begin
      reload_d = bus.load_val;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (r_eff != '0) begin
            state_d = RUN;
            q_d     = r_eff;
          end else begin
            q_d    = '0;
            done_d = 1'b1;
          end
        end else if (bus.load) begin
          q_d = bus.load_val;
        end
      end

      RUN: begin
        // stop wins over terminal count, decrement and start.
        if (bus.stop) begin
          state_d = IDLE;
        end else if (terminal) begin
          done_d = 1'b1;
          if (reload_hit) begin
            q_d = reload_q;
          end else begin
            state_d = IDLE;
            q_d     = '0;
          end
        end else if (bus.cen && (q_q > WIDTH'(1))) begin
          q_d = q_q - WIDTH'(1);
        end else if (q_q == '0) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= RELOAD_INIT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sync_unf = terminal;

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - scoreboard bench for down_timer (covers DOWN_TIMER_AUTO_RELOAD_EN when defined).
module tb_down_timer;

  logic clk;
  logic rst;

  down_timer_if #(.WIDTH(16)) tif ();

  down_timer #(.WIDTH(16), .RELOAD_INIT(16'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic        busy;
    logic        done;
    logic        unf;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Values shown during a cycle: registered q/busy/done from the previous edge,
  // combinational sync_unf from the inputs driven in this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, {13'd0, tif.q, tif.busy, tif.done, tif.sync_unf},
                    {13'd0, e.q, e.busy, e.done, e.unf});
    end
  end

  task automatic step(input string name, input logic c, input logic ld, input logic [15:0] lv,
                      input logic st, input logic sp, input logic pr,
                      input logic [15:0] eq, input logic eb, input logic ed, input logic eu);
    exp_t e;
    @(posedge clk);
    #1;
    tif.cen      = c;
    tif.load     = ld;
    tif.load_val = lv;
    tif.start    = st;
    tif.stop     = sp;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    tif.periodic = pr;
`else
    if (pr) $display("periodic ignored in one-shot build");
`endif
    e.q = eq; e.busy = eb; e.done = ed; e.unf = eu; e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    tif.cen = 0; tif.load = 0; tif.load_val = 0; tif.start = 0; tif.stop = 0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    tif.periodic = 0;
`endif
    #2 rst = 1'b1;
    #1;
    check("reset_state", {13'd0, tif.q, tif.busy, tif.done, tif.sync_unf}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // One-shot count of 4
    step("t1_load",  1, 1, 16'd4, 0, 0, 0,  16'd0, 0, 0, 0);
    step("t1_start", 1, 0, 16'd0, 1, 0, 0,  16'd4, 0, 0, 0);
    step("t1_q4",    1, 0, 16'd0, 0, 0, 0,  16'd4, 1, 0, 0);
    step("t1_q3",    1, 0, 16'd0, 0, 0, 0,  16'd3, 1, 0, 0);
    step("t1_q2",    1, 0, 16'd0, 0, 0, 0,  16'd2, 1, 0, 0);
    step("t1_q1",    1, 0, 16'd0, 0, 0, 0,  16'd1, 1, 0, 1);
    step("t1_done",  1, 0, 16'd0, 0, 0, 0,  16'd0, 0, 1, 0);
    step("t1_after", 1, 0, 16'd0, 0, 0, 0,  16'd0, 0, 0, 0);

    // cen gating, R=3 loaded together with start
    step("t2_start", 0, 1, 16'd3, 1, 0, 0,  16'd0, 0, 0, 0);
    step("t2_c1",    1, 0, 16'd0, 0, 0, 0,  16'd3, 1, 0, 0);
    step("t2_c0a",   0, 0, 16'd0, 0, 0, 0,  16'd2, 1, 0, 0);
    step("t2_c1b",   1, 0, 16'd0, 0, 0, 0,  16'd2, 1, 0, 0);
    step("t2_c0b",   0, 0, 16'd0, 0, 0, 0,  16'd1, 1, 0, 0);
    step("t2_c1c",   1, 0, 16'd0, 0, 0, 0,  16'd1, 1, 0, 1);
    step("t2_done",  0, 0, 16'd0, 0, 0, 0,  16'd0, 0, 1, 0);
    step("t2_after", 0, 0, 16'd0, 0, 0, 0,  16'd0, 0, 0, 0);

    // stop coinciding with terminal count, then stop in IDLE
    step("t3_start", 0, 1, 16'd2, 1, 0, 0,  16'd0, 0, 0, 0);
    step("t3_q2",    1, 0, 16'd0, 0, 0, 0,  16'd2, 1, 0, 0);
    step("t3_stop",  1, 0, 16'd0, 0, 1, 0,  16'd1, 1, 0, 0);
    step("t3_idle",  1, 0, 16'd0, 0, 1, 0,  16'd1, 0, 0, 0);
    step("t3_hold",  1, 0, 16'd0, 0, 0, 0,  16'd1, 0, 0, 0);

    // Zero-length interval
    step("t4_zero",  1, 1, 16'd0, 1, 0, 0,  16'd1, 0, 0, 0);
    step("t4_done",  1, 0, 16'd0, 0, 0, 0,  16'd0, 0, 1, 0);
    step("t4_after", 1, 0, 16'd0, 0, 0, 0,  16'd0, 0, 0, 0);

    // start ignored in RUN; load in RUN leaves q alone and applies at next start
    step("t5_start", 0, 1, 16'd7, 1, 0, 0,  16'd0, 0, 0, 0);
    step("t5_q7",    0, 0, 16'd0, 0, 0, 0,  16'd7, 1, 0, 0);
    step("t5_rest",  1, 0, 16'd0, 1, 0, 0,  16'd7, 1, 0, 0);
    step("t5_q6",    1, 0, 16'd0, 0, 0, 0,  16'd6, 1, 0, 0);
    step("t5_ldrun", 0, 1, 16'd9, 0, 0, 0,  16'd5, 1, 0, 0);
    step("t5_stop",  0, 0, 16'd0, 0, 1, 0,  16'd5, 1, 0, 0);
    step("t5_st9",   0, 0, 16'd0, 1, 0, 0,  16'd5, 0, 0, 0);
    step("t5_stop9", 0, 0, 16'd0, 0, 1, 0,  16'd9, 1, 0, 0);
    step("t5_idle",  0, 0, 16'd0, 0, 0, 0,  16'd9, 0, 0, 0);

    // Asynchronous reset while counting at q=5
    step("t6_start", 0, 1, 16'd5, 1, 0, 0,  16'd9, 0, 0, 0);
    step("t6_q5",    1, 0, 16'd0, 0, 0, 0,  16'd5, 1, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_async_rst", {13'd0, tif.q, tif.busy, tif.done, tif.sync_unf}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    // Reload register is back to RELOAD_INIT=0, so start gives a zero interval.
    step("t6_start0", 1, 0, 16'd0, 1, 0, 0, 16'd0, 0, 0, 0);
    step("t6_done",   1, 0, 16'd0, 0, 0, 0, 16'd0, 0, 1, 0);
    step("t6_after",  1, 0, 16'd0, 0, 0, 0, 16'd0, 0, 0, 0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    step("p_start",  1, 1, 16'd2, 1, 0, 1,  16'd0, 0, 0, 0);
    step("p_q2",     1, 0, 16'd0, 0, 0, 1,  16'd2, 1, 0, 0);
    step("p_q1",     1, 0, 16'd0, 0, 0, 1,  16'd1, 1, 0, 1);
    step("p_rl_ld3", 1, 1, 16'd3, 0, 0, 1,  16'd2, 1, 1, 0);
    step("p_q1b",    1, 0, 16'd0, 0, 0, 1,  16'd1, 1, 0, 1);
    step("p_q3",     1, 0, 16'd0, 0, 0, 1,  16'd3, 1, 1, 0);
    step("p_q2b",    1, 0, 16'd0, 0, 0, 1,  16'd2, 1, 0, 0);
    step("p_q1c",    1, 0, 16'd0, 0, 0, 1,  16'd1, 1, 0, 1);
    step("p_q3b",    1, 0, 16'd0, 0, 0, 1,  16'd3, 1, 1, 0);
    step("p_stop",   1, 0, 16'd0, 0, 1, 1,  16'd2, 1, 0, 0);
    step("p_idle",   1, 0, 16'd0, 0, 0, 0,  16'd2, 0, 0, 0);
`endif

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
